// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encodings,
// word geometry and header width.
package inst_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_W          = 16;
    localparam int unsigned LANE_W         = 2;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        LOAD   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Loader bus bundle: host byte link (rx_*) plus the lsu instruction-write port.
// master = loader side, slave = host/lsu side.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              working;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, addr, wr, wdata, working
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, addr, wr, wdata, working
    );
endinterface

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into a word; word_valid pulses
// for one cycle after the last lane is accepted and word holds otherwise.
module byte_packer
    import inst_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [LANE_W-1:0] lane,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    // Lower three bytes of the word in progress, newest byte at the top.
    logic [DATA_W-9:0] partial;

    // Lane counter, shift register and word output with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            lane       <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                partial <= {byte_in, partial[DATA_W-9:8]};
                lane    <= lane + LANE_W'(1);
                if (lane == LANE_LAST) begin
                    word       <= {byte_in, partial};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: host-side program loader. Parses a length header, packs the
// byte stream into words, writes them to the lsu port and then raises working.
// Optional trailing XOR checksum: define INST_LOADER_CHECKSUM_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    inst_loader_if.master     bus,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD       = CHK;
    localparam logic   AFTER_LOAD_READY = 1'b1;
    logic [7:0] xsum;
`else
    localparam state_t AFTER_LOAD       = DONE;
    localparam logic   AFTER_LOAD_READY = 1'b0;
`endif

    state_t            state;
    logic [HDR_W-1:0]  len;
    logic [LANE_W-1:0] lane;
    logic              fire_c;
    logic              last_byte_c;
    logic [HDR_W-1:0]  hdr_len_c;

    assign fire_c      = bus.rx_valid & bus.rx_ready;
    assign last_byte_c = fire_c && (state == LOAD) && (lane == LANE_LAST);
    assign hdr_len_c   = {bus.rx_data, len[7:0]};

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (fire_c && (state == LOAD)),
        .byte_in    (bus.rx_data),
        .lane       (lane),
        .word_valid (bus.wr),
        .word       (bus.wdata)
    );

    // Frame FSM, word counter, write address and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= HDR_LO;
            len          <= '0;
            bus.addr     <= '0;
            bus.working  <= 1'b0;
            bus.rx_ready <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            bus.rx_ready <= (state != DONE) && (state != ERR);
            case (state)
                HDR_LO: begin
                    if (fire_c) begin
                        len[7:0] <= bus.rx_data;
                        state    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (fire_c) begin
                        len <= hdr_len_c;
                        if (32'(hdr_len_c) > DEPTH) begin
                            state        <= ERR;
                            err          <= 1'b1;
                            bus.rx_ready <= 1'b0;
                        end else if (hdr_len_c == '0) begin
                            state        <= AFTER_LOAD;
                            bus.rx_ready <= AFTER_LOAD_READY;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // addr/count register alongside the packer's write strobe
                    if (last_byte_c) begin
                        bus.addr     <= words_loaded[ADDR_W-1:0];
                        words_loaded <= words_loaded + CNT_W'(1);
                        if (HDR_W'(words_loaded) + HDR_W'(1) == len) begin
                            state        <= AFTER_LOAD;
                            bus.rx_ready <= AFTER_LOAD_READY;
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CHK: begin
                    if (fire_c) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == xsum) begin
                            state <= DONE;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    bus.working <= 1'b1;
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= HDR_LO;
                end
            endcase
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running XOR over header and data bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            xsum <= '0;
        end else if (fire_c && (state == HDR_LO || state == HDR_HI || state == LOAD)) begin
            xsum <= xsum ^ bus.rx_data;
        end
    end
`endif

endmodule
